// File: rtl/instr_encoder.sv
// instr_encoder: packs RV64 instruction fields into a 32-bit word, range-checks the immediate, queues results in an output FIFO
// Optional feature: define INSTR_ENCODER_ERR_CNT_EN to add err_cnt_o, a saturating count of accepted requests that erred.
// Ports:
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   flush_i                 synchronous clear of FIFO contents (wins over push/pop)
//   req_valid_i/req_ready_o request handshake; fields fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i
//   rsp_valid_o/rsp_ready_i response handshake; rsp_instr_o encoded word (0 on error), rsp_err_o
//   err_cnt_o               (optional) error counter
module instr_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [63:0] imm_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_instr_o,
  output logic        rsp_err_o
`ifdef INSTR_ENCODER_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic          w_fits12, w_fitsb, w_fitsu, w_fitsj, w_fitsc, w_err;
  logic [31:0]   w_enc;
  logic          w_push, w_pop, w_full;
  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  // a field fits when every bit above its sign bit matches the sign bit
  always_comb begin
    w_fits12 = &imm_i[63:11] | ~|imm_i[63:11];
    w_fitsb  = ~imm_i[0] & (&imm_i[63:12] | ~|imm_i[63:12]);
    w_fitsu  = ~|imm_i[11:0] & (&imm_i[63:31] | ~|imm_i[63:31]);
    w_fitsj  = ~imm_i[0] & (&imm_i[63:20] | ~|imm_i[63:20]);
    w_fitsc  = ~|imm_i[63:5];
    w_err    = (fmt_i == 3'd1 || fmt_i == 3'd2) ? !w_fits12 :
               fmt_i == 3'd3 ? !w_fitsb :
               fmt_i == 3'd4 ? !w_fitsu :
               fmt_i == 3'd5 ? !w_fitsj :
               fmt_i == 3'd6 ? !w_fitsc :
               fmt_i == 3'd7;
    w_enc    = w_err ? 32'h0 :
               fmt_i == 3'd1 ? {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i} :
               fmt_i == 3'd2 ? {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i} :
               fmt_i == 3'd3 ? {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i} :
               fmt_i == 3'd4 ? {imm_i[31:12], rd_i, opcode_i} :
               fmt_i == 3'd5 ? {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i} :
               fmt_i == 3'd6 ? {funct7_i, rs2_i, imm_i[4:0], funct3_i, rd_i, opcode_i} :
               {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
  end
  assign w_full      = r_cnt == CW'(FIFO_DEPTH);
  assign req_ready_o = !w_full && !flush_i;
  assign w_push      = req_valid_i && req_ready_o;
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign rsp_valid_o = r_cnt != '0;
  // head slot drives the outputs; when empty it is stale and consumers ignore it
  assign rsp_instr_o = r_mem[r_rptr][31:0];
  assign rsp_err_o   = r_mem[r_rptr][32];
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_mem[r_wptr] <= {w_err, w_enc};
      r_wptr <= r_wptr + AW'(w_push);
      r_rptr <= r_rptr + AW'(w_pop);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
`ifdef INSTR_ENCODER_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_err_cnt <= '0;
    else if (w_push && w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign err_cnt_o = r_err_cnt;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a queue-based reference model
module tb_instr_encoder;
  localparam int DEPTH = 2;
  logic        clk_i = 1'b0, rstn_i, flush_i, req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [2:0]  fmt_i, funct3_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [63:0] imm_i;
  logic [31:0] rsp_instr_o;
`ifdef INSTR_ENCODER_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif
  int vectors = 0, miscompares = 0, n_err = 0;
  logic [32:0] q[$];
  logic [32:0] wa, wb, wc, word;
  logic        exp_rdy;
  logic [63:0] bnd [16] = '{64'd2047, 64'd2048, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_F7FF,
                            64'd4094, 64'd4096, 64'hFFFF_FFFF_FFFF_F000, 64'd31, 64'd32,
                            64'h7FFF_F000, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 64'hF_FFFE,
                            64'h10_0000, 64'hFFFF_FFFF_FFF0_0000, 64'd0};

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
    .funct7_i(funct7_i), .imm_i(imm_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_instr_o(rsp_instr_o), .rsp_err_o(rsp_err_o)
`ifdef INSTR_ENCODER_ERR_CNT_EN
    , .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic longint unsigned fld(input longint unsigned v, input int lo, input int n);
    return (v >> lo) & ((64'd1 << n) - 64'd1);
  endfunction

  // reference: legality from numeric ranges of the immediate, encoding from shifted bit-fields
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [63:0] imm);
    longint          s;
    longint unsigned u, w, base;
    bit              ok;
    s    = longint'(imm);
    u    = imm;
    ok   = 1'b1;
    base = 64'(op) | (64'(f3) << 12);
    case (f)
      3'd0: w = base | (64'(rd) << 7) | (64'(rs1) << 15) | (64'(rs2) << 20) | (64'(f7) << 25);
      3'd1: begin
        ok = s >= -64'sd2048 && s <= 64'sd2047;
        w  = base | (64'(rd) << 7) | (64'(rs1) << 15) | (fld(u, 0, 12) << 20);
      end
      3'd2: begin
        ok = s >= -64'sd2048 && s <= 64'sd2047;
        w  = base | (fld(u, 0, 5) << 7) | (64'(rs1) << 15) | (64'(rs2) << 20) | (fld(u, 5, 7) << 25);
      end
      3'd3: begin
        ok = (u % 2 == 0) && s >= -64'sd4096 && s <= 64'sd4095;
        w  = base | (fld(u, 11, 1) << 7) | (fld(u, 1, 4) << 8) | (64'(rs1) << 15) | (64'(rs2) << 20)
                  | (fld(u, 5, 6) << 25) | (fld(u, 12, 1) << 31);
      end
      3'd4: begin
        ok = (u % 4096 == 0) && s >= -64'sd2147483648 && s <= 64'sd2147483647;
        w  = 64'(op) | (64'(rd) << 7) | (fld(u, 12, 20) << 12);
      end
      3'd5: begin
        ok = (u % 2 == 0) && s >= -64'sd1048576 && s <= 64'sd1048575;
        w  = 64'(op) | (64'(rd) << 7) | (fld(u, 12, 8) << 12) | (fld(u, 11, 1) << 20)
                     | (fld(u, 1, 10) << 21) | (fld(u, 20, 1) << 31);
      end
      3'd6: begin
        ok = u < 64'd32;
        w  = base | (64'(rd) << 7) | (fld(u, 0, 5) << 15) | (64'(rs2) << 20) | (64'(f7) << 25);
      end
      default: begin
        ok = 1'b0;
        w  = 64'd0;
      end
    endcase
    return ok ? {1'b0, w[31:0]} : {1'b1, 32'h0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm);
    fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3; funct7_i = f7; imm_i = imm;
  endtask

  function automatic logic [32:0] cur_ref();
    return ref_enc(fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
  endfunction

  task automatic rand_req(input logic [2:0] f);
    logic [63:0] r;
    int          k;
    r = {$urandom, $urandom};
    k = $urandom_range(0, 4);
    set_req(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
            k == 0 ? bnd[$urandom_range(0, 15)] : k == 1 ? 64'($signed(r[12:0])) :
            k == 2 ? 64'($signed(r[21:0])) : k == 3 ? (64'($signed(r[32:0])) & ~64'hFFF) : r);
  endtask

  task automatic one(input string tag, input logic [32:0] exp);
    req_valid_i = 1'b1;
    #1 check({tag, "_rdy"}, 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check({tag, "_vld"}, 64'(rsp_valid_o), 64'd1);
    check({tag, "_instr"}, 64'(rsp_instr_o), 64'(exp[31:0]));
    check({tag, "_err"}, 64'(rsp_err_o), 64'(exp[32]));
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check({tag, "_pop"}, 64'(rsp_valid_o), 64'd0);
  endtask

  initial begin
    rstn_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    #2 rstn_i = 1'b0;
    #2;
    check("rst_vld", 64'(rsp_valid_o), 64'd0);
    check("rst_instr", 64'(rsp_instr_o), 64'd0);
    check("rst_err", 64'(rsp_err_o), 64'd0);
    check("rst_rdy", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); @(posedge clk_i); #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    // directed encodings and error cases
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF); one("i_neg1", {1'b0, 32'hFFF00093});
    set_req(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC); one("s_neg4", {1'b0, 32'hFE21AE23});
    set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);          one("u_lui", {1'b0, 32'h123452B7});
    set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd8);                  one("b_8", {1'b0, 32'h00000463});
    set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h800);                one("j_800", {1'b0, 32'h001000EF});
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);               one("i_2048", {1'b1, 32'h0});
    set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3);                  one("b_odd", {1'b1, 32'h0});
    set_req(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 64'd0);                  one("fmt7", {1'b1, 32'h0});
    n_err = 3;
`ifdef INSTR_ENCODER_ERR_CNT_EN
    check("err_cnt_dir", 64'(err_cnt_o), 64'd3);
`endif
    // backpressure: fill, block third request, drain in order
    rsp_ready_i = 1'b0;
    rand_req(3'd0); wa = cur_ref(); req_valid_i = 1'b1;
    @(posedge clk_i); #1 check("bp_rdy1", 64'(req_ready_o), 64'd1);
    rand_req(3'd0); wb = cur_ref();
    @(posedge clk_i); #1 check("bp_full", 64'(req_ready_o), 64'd0);
    rand_req(3'd0); wc = cur_ref();
    @(posedge clk_i); #1;
    check("bp_blk_rdy", 64'(req_ready_o), 64'd0);
    check("bp_head_a", 64'({rsp_err_o, rsp_instr_o}), 64'(wa));
    rsp_ready_i = 1'b1;
    #1 check("bp_pop_no_push", 64'(req_ready_o), 64'd0);
    @(posedge clk_i); #1;
    check("bp_head_b", 64'({rsp_err_o, rsp_instr_o}), 64'(wb));
    check("bp_rdy2", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;
    check("bp_head_c", 64'({rsp_err_o, rsp_instr_o}), 64'(wc));
    check("bp_vld_c", 64'(rsp_valid_o), 64'd1);
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("bp_drained", 64'(rsp_valid_o), 64'd0);
    rsp_ready_i = 1'b0;
    // randomized traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      rand_req(3'($urandom));
      req_valid_i = $urandom_range(0, 3) != 0;
      rsp_ready_i = $urandom_range(0, 2) != 0;
      flush_i     = $urandom_range(0, 24) == 0;
      #1;
      exp_rdy = q.size() < DEPTH && !flush_i;
      check("rnd_rdy", 64'(req_ready_o), 64'(exp_rdy));
      check("rnd_vld", 64'(rsp_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) check("rnd_head", 64'({rsp_err_o, rsp_instr_o}), 64'(q[0]));
      word = cur_ref();
      @(posedge clk_i); #1;
      if (flush_i) q.delete();
      else begin
        if (q.size() != 0 && rsp_ready_i) void'(q.pop_front());
        if (req_valid_i && exp_rdy) begin
          q.push_back(word);
          if (word[32]) n_err++;
        end
      end
    end
    flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rnd_drain", 64'(rsp_valid_o), 64'd0);
`ifdef INSTR_ENCODER_ERR_CNT_EN
    check("err_cnt_rnd", 64'(err_cnt_o), 64'(n_err));
`endif
    // flush while holding two entries with a request offered
    rsp_ready_i = 1'b0;
    rand_req(3'd0); req_valid_i = 1'b1;
    @(posedge clk_i); #1 rand_req(3'd0);
    @(posedge clk_i); #1;
    check("fl_full_vld", 64'(rsp_valid_o), 64'd1);
    flush_i = 1'b1;
    #1 check("fl_rdy_forced", 64'(req_ready_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    #1;
    check("fl_empty", 64'(rsp_valid_o), 64'd0);
    check("fl_rdy", 64'(req_ready_o), 64'd1);
    // asynchronous reset mid-stream
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5); req_valid_i = 1'b1;
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    check("ar_pre_vld", 64'(rsp_valid_o), 64'd1);
    #2 rstn_i = 1'b0;
    #1;
    check("ar_vld", 64'(rsp_valid_o), 64'd0);
    check("ar_instr", 64'(rsp_instr_o), 64'd0);
    check("ar_err", 64'(rsp_err_o), 64'd0);
    check("ar_rdy", 64'(req_ready_o), 64'd1);
`ifdef INSTR_ENCODER_ERR_CNT_EN
    check("ar_err_cnt", 64'(err_cnt_o), 64'd0);
`endif
    @(posedge clk_i); #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
